// File: rtl/cdb_pkg.sv
// Shared types and widths for the common data bus transmit side.
//   PRF_IDX_W / ROB_IDX_W / BR_TAG_W : physical tag, ROB index and branch mask widths
//   cdb_pkt_t  : one registered broadcast {vld, tag, rob_idx}
//   cdb_slot_t : one held FU completion {tag, rob_idx, br_tag}
//   ptr_w()    : width of a round-robin pointer over n requesters
package cdb_pkg;

  localparam int PRF_IDX_W = 6;
  localparam int ROB_IDX_W = 5;
  localparam int BR_TAG_W  = 4;

  typedef struct packed {
    logic                 vld;
    logic [PRF_IDX_W-1:0] tag;
    logic [ROB_IDX_W-1:0] rob_idx;
  } cdb_pkt_t;

  typedef struct packed {
    logic [PRF_IDX_W-1:0] tag;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [BR_TAG_W-1:0]  br_tag;
  } cdb_slot_t;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_bcast_rr_arb.sv
// Combinational round-robin arbiter.
//   req [N]   : requesters
//   ptr       : highest-priority requester index this cycle
//   gnt [N]   : one-hot grant (all zero when no request)
// Rotates the request vector so ptr lands on bit 0, takes the lowest set bit,
// then rotates the one-hot result back. Works for any N, not just powers of two.
module rr_arb #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] gnt_dbl;
  logic [N-1:0]   rot;
  logic [N-1:0]   pick;
  logic           found;

  always_comb begin
    req_dbl = {req, req} >> ptr;
    rot     = req_dbl[N-1:0];
    pick    = '0;
    found   = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!found && rot[j]) begin
        pick[j] = 1'b1;
        found   = 1'b1;
      end
    end
    gnt_dbl = {pick, pick} << ptr;
    gnt     = gnt_dbl[2*N-1:N];
  end

endmodule

// File: rtl/cdb_bcast.sv
// CDB transmit side: one holding slot per functional unit, round-robin
// arbitration among held completions, one registered broadcast per cycle.
//   clk, rst_n          : clock, async active-low reset
//   fu_done_vld_i/rdy_o : per-FU completion handshake
//   fu_dest_tag_i       : packed dest PRF tags (FU i at [i*PRF_IDX_W +: PRF_IDX_W])
//   fu_rob_idx_i        : packed ROB indices
//   fu_br_tag_i         : packed branch masks
//   br_recovery_i       : mispredict recovery pulse
//   br_tag_fix_i        : mask of squashed branches
//   cdb_vld_o/tag_o/rob_idx_o/src_o : registered broadcast and one-hot winner
// Field widths come from cdb_pkg.
module cdb_bcast
  import cdb_pkg::*;
#(
  parameter int NUM_FU = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_FU-1:0]             fu_done_vld_i,
  output logic [NUM_FU-1:0]             fu_done_rdy_o,
  input  logic [NUM_FU*PRF_IDX_W-1:0]   fu_dest_tag_i,
  input  logic [NUM_FU*ROB_IDX_W-1:0]   fu_rob_idx_i,
  input  logic [NUM_FU*BR_TAG_W-1:0]    fu_br_tag_i,
  input  logic                          br_recovery_i,
  input  logic [BR_TAG_W-1:0]           br_tag_fix_i,
  output logic                          cdb_vld_o,
  output logic [PRF_IDX_W-1:0]          cdb_tag_o,
  output logic [ROB_IDX_W-1:0]          cdb_rob_idx_o,
  output logic [NUM_FU-1:0]             cdb_src_o
);

  localparam int PTR_W = ptr_w(NUM_FU);

  cdb_slot_t         slot_q [NUM_FU];
  logic [NUM_FU-1:0] slot_vld_q;
  logic [NUM_FU-1:0] kill;
  logic [NUM_FU-1:0] req;
  logic [NUM_FU-1:0] grant;
  logic [NUM_FU-1:0] load;
  logic [PTR_W-1:0]  ptr_q;
  logic [PTR_W-1:0]  ptr_nxt;
  cdb_pkt_t          pkt_q;
  cdb_pkt_t          pkt_nxt;
  logic [NUM_FU-1:0] src_q;

  // Squashed slots are removed from the request set before arbitration so a
  // dying completion can never win the bus.
  always_comb begin
    kill = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      kill[i] = br_recovery_i & (|(slot_q[i].br_tag & br_tag_fix_i));
    end
    req = slot_vld_q & ~kill;
  end

  rr_arb #(
    .N     (NUM_FU),
    .PTR_W (PTR_W)
  ) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (grant)
  );

  assign fu_done_rdy_o = ~slot_vld_q | grant;

  // A squashed incoming completion still completes its handshake but is not stored.
  always_comb begin
    load    = '0;
    pkt_nxt = '0;
    ptr_nxt = ptr_q;
    for (int i = 0; i < NUM_FU; i++) begin
      load[i] = fu_done_vld_i[i] & fu_done_rdy_o[i]
              & ~(br_recovery_i & (|(fu_br_tag_i[i*BR_TAG_W +: BR_TAG_W] & br_tag_fix_i)));
      if (grant[i]) begin
        pkt_nxt.vld     = 1'b1;
        pkt_nxt.tag     = slot_q[i].tag;
        pkt_nxt.rob_idx = slot_q[i].rob_idx;
        ptr_nxt         = (i == NUM_FU - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  // A refill in the grant cycle overrides the clear: the new entry wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_vld_q <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (load[i]) begin
          slot_vld_q[i]     <= 1'b1;
          slot_q[i].tag     <= fu_dest_tag_i[i*PRF_IDX_W +: PRF_IDX_W];
          slot_q[i].rob_idx <= fu_rob_idx_i[i*ROB_IDX_W +: ROB_IDX_W];
          slot_q[i].br_tag  <= fu_br_tag_i[i*BR_TAG_W +: BR_TAG_W];
        end else if (grant[i] || kill[i]) begin
          slot_vld_q[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      pkt_q <= '0;
      src_q <= '0;
    end else begin
      ptr_q <= ptr_nxt;
      pkt_q <= pkt_nxt;
      src_q <= grant;
    end
  end

  assign cdb_vld_o     = pkt_q.vld;
  assign cdb_tag_o     = pkt_q.tag;
  assign cdb_rob_idx_o = pkt_q.rob_idx;
  assign cdb_src_o     = src_q;

endmodule
